// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, parser states and width helper for the SPI command decoder.
package spi_cmd_pkg;

    localparam logic [7:0] OP_WR     = 8'h80;
    localparam logic [7:0] OP_RD     = 8'h81;
    localparam logic [7:0] OP_STREAM = 8'h55;
    localparam logic [7:0] OP_SCR0   = 8'h40;
    localparam logic [7:0] OP_SCR1   = 8'h41;
    localparam logic [7:0] OP_CLROVF = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_ADDR,
        ST_W_DATA,
        ST_R_ADDR,
        ST_R_DATA,
        ST_STREAM,
        ST_IGNORE
    } state_t;

    // Bits needed to hold the value mval (at least 1).
    function automatic int unsigned mval_w(input int unsigned mval);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((mval >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_pix_packer.sv
// Packs stream bytes into multi-pixel beats; first byte of a beat lands in the MSB.
module pix_packer
    import spi_cmd_pkg::*;
#(
    parameter int unsigned PIX_BYTES = 3,
    parameter int unsigned PIX_CH    = 2
) (
    input  logic                            clk_p,
    input  logic                            rst_p,
    input  logic                            clr,
    input  logic                            stb,
    input  logic [7:0]                      dat,
    input  logic                            rdy,
    output logic                            pix_vld,
    output logic [PIX_CH*PIX_BYTES*8-1:0]   pix_dat,
    output logic                            ovf_c
);

    localparam int unsigned BEAT_BYTES = PIX_CH * PIX_BYTES;
    localparam int unsigned BEAT_W     = BEAT_BYTES * 8;
    localparam int unsigned CW         = mval_w(BEAT_BYTES - 1);

    logic [BEAT_W-1:0] shreg;
    logic [BEAT_W-1:0] shifted;
    logic [CW-1:0]     cnt;
    logic              last;

    // Next shift-register contents and beat-complete detection.
    assign last    = (cnt == CW'(BEAT_BYTES - 1));
    assign shifted = (shreg << 8) | BEAT_W'(dat);
    assign ovf_c   = stb && !clr && last && !rdy;

    // Shift bytes in; on the last byte of a beat publish it and wrap the counter.
    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            shreg   <= '0;
            cnt     <= '0;
            pix_vld <= 1'b0;
            pix_dat <= '0;
        end else begin
            pix_vld <= 1'b0;
            if (clr) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (stb) begin
                shreg <= shifted;
                if (last) begin
                    cnt     <= '0;
                    pix_vld <= 1'b1;
                    pix_dat <= shifted;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI transaction parser: burst register access, screen reset control and pixel streaming.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int unsigned REG_N     = 8,
    parameter int unsigned PIX_BYTES = 3,
    parameter int unsigned PIX_CH    = 2
) (
    input  logic                            clk_p,
    input  logic                            rst_p,
    input  logic                            css_act,
    input  logic                            byte_vld,
    input  logic [7:0]                      byte_dat,
    input  logic [7:0]                      ret_dat,
    input  logic                            pix_rdy,
    output logic [7:0]                      tx_dat,
    output logic [REG_N*8-1:0]              reg_flat,
    output logic                            pix_vld,
    output logic [PIX_CH*PIX_BYTES*8-1:0]   pix_dat,
    output logic                            scr_rst,
    output logic                            stream_act,
    output logic                            pix_ovf
);

    localparam int unsigned AW = mval_w(REG_N - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   addr, addr_nxt;
    logic [AW-1:0]   rd_idx;
    logic            addr_bad, addr_bad_nxt;
    logic [7:0]      tx_nxt;
    logic            scr_nxt;
    logic            stream_nxt;
    logic            ovf_nxt;
    logic            ovf_clr;
    logic            ovf_c;
    logic            wr_en;
    logic            pk_clr;
    logic            pk_stb;

    // Beat assembly for stream mode.
    pix_packer #(
        .PIX_BYTES (PIX_BYTES),
        .PIX_CH    (PIX_CH)
    ) u_packer (
        .clk_p   (clk_p),
        .rst_p   (rst_p),
        .clr     (pk_clr),
        .stb     (pk_stb),
        .dat     (byte_dat),
        .rdy     (pix_rdy),
        .pix_vld (pix_vld),
        .pix_dat (pix_dat),
        .ovf_c   (ovf_c)
    );

    // Parser next-state and next-output decode; an inactive select aborts everything.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        addr_bad_nxt = addr_bad;
        tx_nxt       = tx_dat;
        scr_nxt      = scr_rst;
        stream_nxt   = stream_act;
        ovf_clr      = 1'b0;
        wr_en        = 1'b0;
        pk_clr       = 1'b0;
        pk_stb       = 1'b0;
        rd_idx       = byte_dat[AW-1:0];

        if (!css_act) begin
            state_nxt  = ST_IDLE;
            stream_nxt = 1'b0;
            pk_clr     = 1'b1;
        end else if (byte_vld) begin
            tx_nxt = 8'hFF;
            case (state)
                ST_IDLE: begin
                    case (byte_dat)
                        OP_WR:     state_nxt = ST_W_ADDR;
                        OP_RD:     state_nxt = ST_R_ADDR;
                        OP_STREAM: begin
                            state_nxt  = ST_STREAM;
                            stream_nxt = 1'b1;
                            pk_clr     = 1'b1;
                        end
                        OP_SCR0: begin
                            scr_nxt   = 1'b0;
                            state_nxt = ST_IGNORE;
                        end
                        OP_SCR1: begin
                            scr_nxt   = 1'b1;
                            state_nxt = ST_IGNORE;
                        end
                        OP_CLROVF: begin
                            ovf_clr   = 1'b1;
                            state_nxt = ST_IGNORE;
                        end
                        default:   state_nxt = ST_IGNORE;
                    endcase
                end
                ST_W_ADDR: begin
                    addr_nxt     = byte_dat[AW-1:0];
                    addr_bad_nxt = (9'(byte_dat) >= 9'(REG_N));
                    state_nxt    = ST_W_DATA;
                end
                ST_W_DATA: begin
                    if (!addr_bad) begin
                        wr_en    = 1'b1;
                        addr_nxt = addr + AW'(1);
                    end
                end
                ST_R_ADDR: begin
                    tx_nxt    = reg_flat[{rd_idx, 3'b000} +: 8];
                    addr_nxt  = rd_idx + AW'(1);
                    state_nxt = ST_R_DATA;
                end
                ST_R_DATA: begin
                    tx_nxt   = reg_flat[{addr, 3'b000} +: 8];
                    addr_nxt = addr + AW'(1);
                end
                ST_STREAM: begin
                    pk_stb = 1'b1;
                    tx_nxt = ret_dat;
                end
                ST_IGNORE: begin
                    state_nxt = ST_IGNORE;
                end
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Overrun flag: a detected overrun takes priority over a clear.
    always_comb begin
        ovf_nxt = pix_ovf;
        if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end
        if (ovf_c) begin
            ovf_nxt = 1'b1;
        end
    end

    // State, control outputs and register file.
    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            state      <= ST_IDLE;
            addr       <= '0;
            addr_bad   <= 1'b0;
            tx_dat     <= 8'hFF;
            scr_rst    <= 1'b0;
            stream_act <= 1'b0;
            pix_ovf    <= 1'b0;
            reg_flat   <= '0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            addr_bad   <= addr_bad_nxt;
            tx_dat     <= tx_nxt;
            scr_rst    <= scr_nxt;
            stream_act <= stream_nxt;
            pix_ovf    <= ovf_nxt;
            if (wr_en) begin
                reg_flat[{addr, 3'b000} +: 8] <= byte_dat;
            end
        end
    end

endmodule
